// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   N-digit multiplexed 7-segment driver. A prescaler divides clk into digit
//   slots; each slot opens with DEAD_CYCLES dark cycles (anti-ghosting), then
//   lights one digit with its hex-decoded nibble. Display data is held in a
//   shadow register that only changes at frame boundaries (or while disabled),
//   so a frame never shows a mix of old and new values.
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   enable       0: display dark, scan parked at the top digit slot
//   load         1-cycle strobe capturing data/dp_in
//   data         nibble i = data[4i+3:4i], digit 0 is the rightmost
//   dp_in        decimal point per digit
//   blank_lz     suppress leading zeros (digit 0 is never blanked)
//   cathode      digit selects, bit i drives digit i
//   segmentout   {dp,g,f,e,d,c,b,a}
//   frame_done   1-cycle pulse aligned with the last cycle of the digit-0 slot
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 2,
    parameter int SEG_ACT_LOW = 1,
    parameter int CAT_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   cathode,
    output logic [7:0]              segmentout,
    output logic                    frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYCLES);
    localparam logic [DW-1:0] PTR_TOP   = DW'(NUM_DIGITS - 1);
    localparam logic [7:0]    SEG_INV   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] CAT_INV =
        (CAT_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]                 presc;
    logic [DW-1:0]                 ptr;
    logic [NUM_DIGITS-1:0][3:0]    pending, shadow;
    logic [NUM_DIGITS-1:0]         pending_dp, shadow_dp;
    logic                          pending_valid;

    // Active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // zero_run[i]: nibbles i..NUM_DIGITS-1 of the shadow are all zero
    logic [NUM_DIGITS-1:0] zero_run;
    logic                  run;
    always_comb begin
        zero_run = '0;
        run      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run         = run & (shadow[i] == 4'h0);
            zero_run[i] = run;
        end
    end

    logic                  boundary, dark, blank_now;
    logic [7:0]            seg_on;
    logic [NUM_DIGITS-1:0] cat_sel;

    assign boundary  = (ptr == '0) && (presc == PRESC_MAX);
    assign dark      = (presc < DEAD_END);
    assign blank_now = blank_lz && (ptr != '0) && zero_run[ptr];
    assign seg_on    = {shadow_dp[ptr], blank_now ? 7'h00 : hex7(shadow[ptr])};
    assign cat_sel   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc         <= '0;
            ptr           <= PTR_TOP;
            pending       <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            shadow        <= '0;
            shadow_dp     <= '0;
            cathode       <= CAT_INV;
            segmentout    <= SEG_INV;
            frame_done    <= 1'b0;
        end else if (!enable) begin
            presc      <= '0;
            ptr        <= PTR_TOP;
            cathode    <= CAT_INV;
            segmentout <= SEG_INV;
            frame_done <= 1'b0;
            // Nothing is on screen, so publish new data right away; the first
            // frame after enable rises then shows the latest values.
            if (load) begin
                shadow    <= data;
                shadow_dp <= dp_in;
            end else if (pending_valid) begin
                shadow    <= pending;
                shadow_dp <= pending_dp;
            end
            pending_valid <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (presc == PRESC_MAX) begin
                presc <= '0;
                ptr   <= (ptr == '0) ? PTR_TOP : ptr - 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            cathode    <= dark ? CAT_INV : (cat_sel ^ CAT_INV);
            segmentout <= dark ? SEG_INV : (seg_on ^ SEG_INV);

            // A load landing on the boundary itself bypasses pending.
            if (boundary) begin
                if (load) begin
                    shadow    <= data;
                    shadow_dp <= dp_in;
                end else if (pending_valid) begin
                    shadow    <= pending;
                    shadow_dp <= pending_dp;
                end
                pending_valid <= 1'b0;
            end else if (load) begin
                pending       <= data;
                pending_dp    <= dp_in;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  cathode;
    logic [7:0]  segmentout;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .PRESCALE(4), .DEAD_CYCLES(1),
        .SEG_ACT_LOW(1), .CAT_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .data(data), .dp_in(dp_in), .blank_lz(blank_lz),
        .cathode(cathode), .segmentout(segmentout), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] cat;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs of one frame (digit 3 slot first), first n cycles only.
    task automatic push_frame(input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0, input int n);
        logic [7:0] s [4];
        exp_t       e;
        int         idx;
        s[3] = s3; s[2] = s2; s[1] = s1; s[0] = s0;
        idx = 0;
        for (int d = 3; d >= 0; d--) begin
            for (int k = 0; k < 4; k++) begin
                e.cat = (k == 0) ? 4'hF : ~(4'b0001 << d);
                e.seg = (k == 0) ? 8'hFF : s[d];
                e.fd  = (d == 0) && (k == 3);
                if (idx < n) sb.push_back(e);
                idx++;
            end
        end
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        e.cat = 4'hF; e.seg = 8'hFF; e.fd = 1'b0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // One cycle: sample at the falling edge and compare with the oldest entry.
    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("cathode", {28'd0, cathode}, {28'd0, e.cat});
                chk("segment", {24'd0, segmentout}, {24'd0, e.seg});
                chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
            end
        end
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_cathode", {28'd0, cathode}, 32'hF);
        chk("rst_segment", {24'd0, segmentout}, 32'hFF);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);

        // scan: zeros first (shadow cleared), then 0123 after the boundary
        rst_n = 1'b1;
        load = 1'b1; data = 16'h0123;
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 16);
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 16);
        step(1);
        load = 1'b0;
        step(31);

        // tear-free: load in the second slot, current frame unchanged
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 16);
        push_frame(8'h99, 8'h92, 8'h82, 8'hF8, 16);
        step(5);
        load = 1'b1; data = 16'h4567;
        step(1);
        load = 1'b0;
        step(26);

        // leading-zero blanking with a dp on a blanked digit
        push_frame(8'h99, 8'h92, 8'h82, 8'hF8, 16);
        push_frame(8'hFF, 8'h7F, 8'hF8, 8'hC0, 16);
        step(3);
        load = 1'b1; data = 16'h0070; dp_in = 4'b0100; blank_lz = 1'b1;
        step(1);
        load = 1'b0;
        step(28);

        // load exactly on the boundary cycle goes straight to the next frame
        push_frame(8'hFF, 8'h7F, 8'hF8, 8'hC0, 16);
        push_frame(8'h80, 8'h90, 8'h88, 8'h03, 16);
        step(15);
        load = 1'b1; data = 16'h89AB; dp_in = 4'b0001; blank_lz = 1'b0;
        step(1);
        load = 1'b0;
        step(16);

        // enable low: dark, no frame_done, pending published; restart at digit 3
        push_frame(8'h80, 8'h90, 8'h88, 8'h03, 7);
        step(6);
        load = 1'b1; data = 16'h1234; dp_in = 4'b0000;
        step(1);
        load = 1'b0; enable = 1'b0;
        push_dark(10);
        step(10);
        enable = 1'b1;
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16);
        step(16);

        // asynchronous reset in the middle of a lit slot
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 6);
        step(6);
        chk("pre_rst_lit", {28'd0, cathode}, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cathode", {28'd0, cathode}, 32'hF);
        chk("async_rst_segment", {24'd0, segmentout}, 32'hFF);
        chk("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 16);
        step(16);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
